tpu_host_arbiter: RTL

TPU_HOST_ARBITER -- requirements
Module: tpu_host_arbiter

---
 rtl/tpu_host_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/tpu_host_arbiter.sv
// tpu_host_arbiter: arbitrates host commands from two requesters (UART and front panel)
// onto the TPU's unified-buffer, weight and instruction write ports and its start strobe.
// UB reads are returned on a shared response bus to the requester that issued them.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   {uart,panel}_cmd_*              command handshake (valid/ready) with op, addr and data
//   {uart,panel}_rsp_valid/_ready   read response handshake; rsp_data is shared
//   ub_wr_*, ub_rd_*, ub_rd_data    unified buffer write and read ports
//   wt_wr_*, instr_wr_*             weight and instruction memory write ports
//   start_execution                 one-cycle start pulse
//   sys_busy, vpu_busy, ub_busy     TPU activity; any of them holds off new commands
//   grant_owner                     0 = UART, 1 = panel; owner of the current/last command
//   err_illegal_op                  one-cycle pulse when an op code 5..7 is issued
module tpu_host_arbiter #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         uart_cmd_valid,
  output logic         uart_cmd_ready,
  input  logic [2:0]   uart_cmd_op,
  input  logic [9:0]   uart_cmd_addr,
  input  logic [255:0] uart_cmd_data,
  output logic         uart_rsp_valid,
  input  logic         uart_rsp_ready,
  input  logic         panel_cmd_valid,
  output logic         panel_cmd_ready,
  input  logic [2:0]   panel_cmd_op,
  input  logic [9:0]   panel_cmd_addr,
  input  logic [255:0] panel_cmd_data,
  output logic         panel_rsp_valid,
  input  logic         panel_rsp_ready,
  output logic [255:0] rsp_data,
  output logic         ub_wr_en,
  output logic [7:0]   ub_wr_addr,
  output logic [255:0] ub_wr_data,
  output logic         ub_rd_en,
  output logic [7:0]   ub_rd_addr,
  input  logic [255:0] ub_rd_data,
  output logic         wt_wr_en,
  output logic [9:0]   wt_wr_addr,
  output logic [63:0]  wt_wr_data,
  output logic         instr_wr_en,
  output logic [4:0]   instr_wr_addr,
  output logic [31:0]  instr_wr_data,
  output logic         start_execution,
  input  logic         sys_busy,
  input  logic         vpu_busy,
  input  logic         ub_busy,
  output logic         grant_owner,
  output logic         err_illegal_op
);

  localparam logic [2:0] OpUbWr    = 3'd0;
  localparam logic [2:0] OpUbRd    = 3'd1;
  localparam logic [2:0] OpWtWr    = 3'd2;
  localparam logic [2:0] OpInstrWr = 3'd3;
  localparam logic [2:0] OpStart   = 3'd4;

  // Capture happens when the counter (0 in the ub_rd_en cycle) reaches RD_LAT.
  localparam logic [2:0] RdLatCnt = 3'(RD_LAT);

  typedef enum logic [1:0] {StIdle, StIssue, StRdWait, StResp} state_e;

  state_e         state_q;
  logic [2:0]     op_q;
  logic [9:0]     addr_q;
  logic [255:0]   data_q;
  logic           last_grant_q;
  logic [2:0]     lat_cnt_q;

  logic           tpu_busy;
  logic           any_valid;
  logic           win_panel;
  logic           owner_rsp_ready;

  always_comb begin
    tpu_busy  = sys_busy | vpu_busy | ub_busy;
    any_valid = uart_cmd_valid | panel_cmd_valid;
    // Round-robin: on contention the requester that did not win last time goes next.
    if (uart_cmd_valid && panel_cmd_valid) begin
      win_panel = ~last_grant_q;
    end else begin
      win_panel = panel_cmd_valid;
    end
    owner_rsp_ready = grant_owner ? panel_rsp_ready : uart_rsp_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      op_q            <= 3'd0;
      addr_q          <= 10'd0;
      data_q          <= 256'd0;
      last_grant_q    <= 1'b1;
      lat_cnt_q       <= 3'd0;
      uart_cmd_ready  <= 1'b0;
      panel_cmd_ready <= 1'b0;
      uart_rsp_valid  <= 1'b0;
      panel_rsp_valid <= 1'b0;
      rsp_data        <= 256'd0;
      ub_wr_en        <= 1'b0;
      ub_wr_addr      <= 8'd0;
      ub_wr_data      <= 256'd0;
      ub_rd_en        <= 1'b0;
      ub_rd_addr      <= 8'd0;
      wt_wr_en        <= 1'b0;
      wt_wr_addr      <= 10'd0;
      wt_wr_data      <= 64'd0;
      instr_wr_en     <= 1'b0;
      instr_wr_addr   <= 5'd0;
      instr_wr_data   <= 32'd0;
      start_execution <= 1'b0;
      grant_owner     <= 1'b0;
      err_illegal_op  <= 1'b0;
    end else begin
      // Strobes are single-cycle; the state that wants one re-asserts it below.
      uart_cmd_ready  <= 1'b0;
      panel_cmd_ready <= 1'b0;
      ub_wr_en        <= 1'b0;
      ub_rd_en        <= 1'b0;
      wt_wr_en        <= 1'b0;
      instr_wr_en     <= 1'b0;
      start_execution <= 1'b0;
      err_illegal_op  <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (any_valid && !tpu_busy) begin
            uart_cmd_ready  <= ~win_panel;
            panel_cmd_ready <= win_panel;
            op_q            <= win_panel ? panel_cmd_op   : uart_cmd_op;
            addr_q          <= win_panel ? panel_cmd_addr : uart_cmd_addr;
            data_q          <= win_panel ? panel_cmd_data : uart_cmd_data;
            last_grant_q    <= win_panel;
            grant_owner     <= win_panel;
            state_q         <= StIssue;
          end
        end

        StIssue: begin
          state_q <= StIdle;
          case (op_q)
            OpUbWr: begin
              ub_wr_en   <= 1'b1;
              ub_wr_addr <= addr_q[7:0];
              ub_wr_data <= data_q;
            end
            OpUbRd: begin
              ub_rd_en   <= 1'b1;
              ub_rd_addr <= addr_q[7:0];
              lat_cnt_q  <= 3'd0;
              state_q    <= StRdWait;
            end
            OpWtWr: begin
              wt_wr_en   <= 1'b1;
              wt_wr_addr <= addr_q;
              wt_wr_data <= data_q[63:0];
            end
            OpInstrWr: begin
              instr_wr_en   <= 1'b1;
              instr_wr_addr <= addr_q[4:0];
              instr_wr_data <= data_q[31:0];
            end
            OpStart: begin
              start_execution <= 1'b1;
            end
            default: begin
              err_illegal_op <= 1'b1;
            end
          endcase
        end

        StRdWait: begin
          if (lat_cnt_q == RdLatCnt) begin
            rsp_data        <= ub_rd_data;
            uart_rsp_valid  <= ~grant_owner;
            panel_rsp_valid <= grant_owner;
            state_q         <= StResp;
          end else begin
            lat_cnt_q <= lat_cnt_q + 3'd1;
          end
        end

        StResp: begin
          if (owner_rsp_ready) begin
            uart_rsp_valid  <= 1'b0;
            panel_rsp_valid <= 1'b0;
            state_q         <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
